dmc_line_transfer_engine: RTL and testbench

- Memory-side stage directly downstream of the direct-mapped cache controller.
- Executes whole-line transfers between a cache line and block-addressed main memory: writeback (flush) of a dirty line, fetch (fill) of a new line, or flush followed by fill.
- Serialises a line into NUM_OF_BLOCKS_PER_LINE single-block memory accesses and absorbs fixed memory read latency.
- The controller sees one start and one done per line.

---
 rtl/dmc_line_transfer_engine_pkg.sv | 30 +++
 rtl/dmc_line_transfer_engine_if.sv | 38 +++
 rtl/dmc_block_counter.sv | 38 +++
 rtl/dmc_line_transfer_engine.sv | 177 +++++++++++++++++
 tb/tb_dmc_line_transfer_engine.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmc_line_transfer_engine_pkg.sv
// Shared widths and state encoding for the direct-mapped cache line transfer engine.
// The cache and controller import the same width constants and helpers.
package dmc_line_transfer_engine_pkg;

    localparam int unsigned DEF_BLOCK_SIZE             = 4;
    localparam int unsigned DEF_NUM_OF_BLOCKS_PER_LINE = 2;
    localparam int unsigned DEF_ADDRESS_SIZE           = 16;
    localparam int unsigned DEF_READ_LATENCY           = 1;

    function automatic int unsigned calc_offset_length(input int unsigned num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int unsigned calc_line_size(input int unsigned num_blocks,
                                                   input int unsigned block_size);
        return num_blocks * block_size;
    endfunction

    localparam int unsigned BLOCK_OFFSET_LENGTH = calc_offset_length(DEF_NUM_OF_BLOCKS_PER_LINE);
    localparam int unsigned LINE_SIZE = calc_line_size(DEF_NUM_OF_BLOCKS_PER_LINE, DEF_BLOCK_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StReadReq,
        StReadWait,
        StDone
    } state_e;

endpackage

// File: rtl/dmc_line_transfer_engine_if.sv
// Controller-side handshake and memory-side block bus of the line transfer engine.
// The engine takes the slave modport; the controller/memory side takes master.
interface dmc_line_transfer_engine_if
    import dmc_line_transfer_engine_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE             = DEF_BLOCK_SIZE,
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = DEF_NUM_OF_BLOCKS_PER_LINE,
    parameter int unsigned ADDRESS_SIZE           = DEF_ADDRESS_SIZE
);
    localparam int unsigned LINE_W = calc_line_size(NUM_OF_BLOCKS_PER_LINE, BLOCK_SIZE);

    logic                    fill_start_i;
    logic                    flush_start_i;
    logic [ADDRESS_SIZE-1:0] fill_address_i;
    logic [ADDRESS_SIZE-1:0] flush_address_i;
    logic [LINE_W-1:0]       flush_line_i;
    logic [LINE_W-1:0]       fill_line_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    mem_read_o;
    logic                    mem_write_o;
    logic [ADDRESS_SIZE-1:0] mem_address_o;
    logic [BLOCK_SIZE-1:0]   mem_data_o;
    logic [BLOCK_SIZE-1:0]   mem_data_i;

    modport master (
        output fill_start_i, flush_start_i, fill_address_i, flush_address_i, flush_line_i,
               mem_data_i,
        input  fill_line_o, busy_o, done_o, mem_read_o, mem_write_o, mem_address_o, mem_data_o
    );

    modport slave (
        input  fill_start_i, flush_start_i, fill_address_i, flush_address_i, flush_line_i,
               mem_data_i,
        output fill_line_o, busy_o, done_o, mem_read_o, mem_write_o, mem_address_o, mem_data_o
    );

endinterface

// File: rtl/dmc_block_counter.sv
// Line-beat counter: clear, increment and a last-beat flag found by comparison.
// count_next_o exposes the value the counter takes at the next edge.
module dmc_block_counter #(
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = 2,
    parameter int unsigned COUNT_W                = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [COUNT_W-1:0] count_next_o,
    output logic               last_o
);

    logic [COUNT_W-1:0] count_q;

    always_comb begin
        count_next_o = count_q;
        if (clear_i) begin
            count_next_o = '0;
        end else if (inc_i) begin
            count_next_o = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_next_o;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == COUNT_W'(NUM_OF_BLOCKS_PER_LINE - 1));

endmodule

// File: rtl/dmc_line_transfer_engine.sv
// Serialises whole-line flush and/or fill into single-block memory accesses,
// absorbing a fixed read latency; one start and one done pulse per line.
module dmc_line_transfer_engine
    import dmc_line_transfer_engine_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE             = DEF_BLOCK_SIZE,
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = DEF_NUM_OF_BLOCKS_PER_LINE,
    parameter int unsigned ADDRESS_SIZE           = DEF_ADDRESS_SIZE,
    parameter int unsigned READ_LATENCY           = DEF_READ_LATENCY
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    dmc_line_transfer_engine_if.slave   bus
);

    localparam int unsigned OFF_W  = calc_offset_length(NUM_OF_BLOCKS_PER_LINE);
    localparam int unsigned LINE_W = calc_line_size(NUM_OF_BLOCKS_PER_LINE, BLOCK_SIZE);
    localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
    localparam logic [ADDRESS_SIZE-1:0] OFF_MASK = ADDRESS_SIZE'(NUM_OF_BLOCKS_PER_LINE - 1);

    state_e                  state_q, state_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    fill_pend_q, fill_pend_d;
    logic [ADDRESS_SIZE-1:0] flush_base_q, flush_base_d;
    logic [ADDRESS_SIZE-1:0] fill_base_q, fill_base_d;
    logic [LINE_W-1:0]       flush_line_q, flush_line_d;
    logic [LINE_W-1:0]       fill_line_q, fill_line_d;

    logic                    busy_q, done_q, rd_q, wr_q;
    logic                    busy_d, done_d, rd_d, wr_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [BLOCK_SIZE-1:0]   data_q, data_d;

    logic                    take_start;
    logic                    slot_wr;
    logic                    blk_clr, blk_inc, blk_last;
    logic [OFF_W-1:0]        blk_q, blk_next;

    dmc_block_counter #(
        .NUM_OF_BLOCKS_PER_LINE (NUM_OF_BLOCKS_PER_LINE),
        .COUNT_W                (OFF_W)
    ) u_block_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (blk_clr),
        .inc_i        (blk_inc),
        .count_o      (blk_q),
        .count_next_o (blk_next),
        .last_o       (blk_last)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        fill_pend_d = fill_pend_q;
        take_start  = 1'b0;
        slot_wr     = 1'b0;
        blk_clr     = 1'b0;
        blk_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.flush_start_i || bus.fill_start_i) begin
                    take_start  = 1'b1;
                    blk_clr     = 1'b1;
                    fill_pend_d = bus.fill_start_i;
                    state_d     = bus.flush_start_i ? StFlush : StReadReq;
                end
            end
            StFlush: begin
                if (blk_last) begin
                    blk_clr = 1'b1;
                    state_d = fill_pend_q ? StReadReq : StDone;
                end else begin
                    blk_inc = 1'b1;
                end
            end
            StReadReq: begin
                lat_d   = '0;
                state_d = StReadWait;
            end
            StReadWait: begin
                if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    slot_wr = 1'b1;
                    if (blk_last) begin
                        blk_clr = 1'b1;
                        state_d = StDone;
                    end else begin
                        blk_inc = 1'b1;
                        state_d = StReadReq;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Capture uses the raw inputs on the start edge so the first beat needs no extra cycle.
    always_comb begin
        flush_base_d = take_start ? (bus.flush_address_i & ~OFF_MASK) : flush_base_q;
        fill_base_d  = take_start ? (bus.fill_address_i & ~OFF_MASK) : fill_base_q;
        flush_line_d = take_start ? bus.flush_line_i : flush_line_q;

        fill_line_d = fill_line_q;
        for (int k = 0; k < int'(NUM_OF_BLOCKS_PER_LINE); k++) begin
            if (slot_wr && (blk_q == OFF_W'(k))) begin
                fill_line_d[k*BLOCK_SIZE +: BLOCK_SIZE] = bus.mem_data_i;
            end
        end
    end

    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        wr_d   = (state_d == StFlush);
        rd_d   = (state_d == StReadReq);
        addr_d = '0;
        data_d = '0;
        if (wr_d) begin
            addr_d = flush_base_d | {{(ADDRESS_SIZE-OFF_W){1'b0}}, blk_next};
            for (int k = 0; k < int'(NUM_OF_BLOCKS_PER_LINE); k++) begin
                if (blk_next == OFF_W'(k)) begin
                    data_d = flush_line_d[k*BLOCK_SIZE +: BLOCK_SIZE];
                end
            end
        end else if (rd_d) begin
            addr_d = fill_base_d | {{(ADDRESS_SIZE-OFF_W){1'b0}}, blk_next};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            fill_pend_q  <= 1'b0;
            flush_base_q <= '0;
            fill_base_q  <= '0;
            flush_line_q <= '0;
            fill_line_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            fill_pend_q  <= fill_pend_d;
            flush_base_q <= flush_base_d;
            fill_base_q  <= fill_base_d;
            flush_line_q <= flush_line_d;
            fill_line_q  <= fill_line_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    assign bus.fill_line_o   = fill_line_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.mem_read_o    = rd_q;
    assign bus.mem_write_o   = wr_q;
    assign bus.mem_address_o = addr_q;
    assign bus.mem_data_o    = data_q;

endmodule

// File: tb/tb_dmc_line_transfer_engine.sv
// Directed bench for the line transfer engine: latency-1 and latency-3 instances,
// each against a block memory preloaded with mem[a] = a[3:0].
module tb_dmc_line_transfer_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmc_line_transfer_engine_if #(.BLOCK_SIZE(4), .NUM_OF_BLOCKS_PER_LINE(2), .ADDRESS_SIZE(16)) bus1();
    dmc_line_transfer_engine_if #(.BLOCK_SIZE(4), .NUM_OF_BLOCKS_PER_LINE(2), .ADDRESS_SIZE(16)) bus3();

    dmc_line_transfer_engine #(.READ_LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    dmc_line_transfer_engine #(.READ_LATENCY(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

    logic [3:0]  mem1 [0:65535];
    logic [3:0]  mem3 [0:65535];
    logic [15:0] p1;
    logic [15:0] q0, q1, q2;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem1[a] = a[3:0];
            mem3[a] = a[3:0];
        end
        p1 = '0; q0 = '0; q1 = '0; q2 = '0;
    end

    // Address pipelines model the fixed read latency of each memory.
    always @(posedge clk) begin
        if (bus1.mem_write_o) mem1[bus1.mem_address_o] <= bus1.mem_data_o;
        if (bus1.mem_read_o)  p1 <= bus1.mem_address_o;
        q0 <= bus3.mem_address_o;
        q1 <= q0;
        q2 <= q1;
    end
    assign bus1.mem_data_i = mem1[p1];
    assign bus3.mem_data_i = mem3[q2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int rd_cyc[$], rd_addr[$], wr_cyc[$], wr_addr[$], wr_data[$], done_cyc[$];
    int idle_nz;

    task automatic run1(input logic fl, input logic fi, input logic [15:0] fa,
                        input logic [15:0] la, input logic [7:0] line, input int poke);
        rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete();
        wr_addr.delete(); wr_data.delete(); done_cyc.delete();
        idle_nz = 0;
        @(negedge clk);
        bus1.flush_start_i   = fl;
        bus1.fill_start_i    = fi;
        bus1.fill_address_i  = fa;
        bus1.flush_address_i = la;
        bus1.flush_line_i    = line;
        @(posedge clk);
        #1;
        bus1.flush_start_i   = 1'b0;
        bus1.fill_start_i    = 1'b0;
        bus1.fill_address_i  = 16'hDEAD;
        bus1.flush_address_i = 16'hBEEF;
        bus1.flush_line_i    = 8'h99;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus1.mem_read_o) begin
                rd_cyc.push_back(c);
                rd_addr.push_back(int'(bus1.mem_address_o));
            end
            if (bus1.mem_write_o) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(int'(bus1.mem_address_o));
                wr_data.push_back(int'(bus1.mem_data_o));
            end
            if (bus1.done_o) done_cyc.push_back(c);
            if (!bus1.mem_read_o && !bus1.mem_write_o &&
                (bus1.mem_address_o != 16'h0 || bus1.mem_data_o != 4'h0)) idle_nz++;
            bus1.fill_start_i  = (c == poke);
            bus1.flush_start_i = (c == poke);
        end
        bus1.fill_start_i  = 1'b0;
        bus1.flush_start_i = 1'b0;
    endtask

    int rd3_cyc[$], rd3_addr[$], done3_cyc[$];

    initial begin
        bus1.fill_start_i = 1'b0; bus1.flush_start_i = 1'b0;
        bus1.fill_address_i = '0; bus1.flush_address_i = '0; bus1.flush_line_i = '0;
        bus3.fill_start_i = 1'b0; bus3.flush_start_i = 1'b0;
        bus3.fill_address_i = '0; bus3.flush_address_i = '0; bus3.flush_line_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus1.busy_o), 0);
        check("rst_done", 32'(bus1.done_o), 0);
        check("rst_rdwr", {30'd0, bus1.mem_read_o, bus1.mem_write_o}, 0);
        check("rst_addr", 32'(bus1.mem_address_o), 0);
        check("rst_line", 32'(bus1.fill_line_o), 0);
        rst = 1'b0;

        run1(1'b0, 1'b1, 16'h0006, 16'h0000, 8'h00, 0);
        check("fill_nrd", rd_cyc.size(), 2);
        check("fill_rd0_cyc", rd_cyc[0], 1);
        check("fill_rd1_cyc", rd_cyc[1], 3);
        check("fill_rd0_addr", rd_addr[0], 32'h6);
        check("fill_rd1_addr", rd_addr[1], 32'h7);
        check("fill_nwr", wr_cyc.size(), 0);
        check("fill_ndone", done_cyc.size(), 1);
        check("fill_done_cyc", done_cyc[0], 5);
        check("fill_line", 32'(bus1.fill_line_o), 32'h76);
        check("fill_idle_bus", idle_nz, 0);

        run1(1'b1, 1'b0, 16'h0000, 16'h0009, 8'hAB, 0);
        check("flush_nwr", wr_cyc.size(), 2);
        check("flush_wr0", {wr_cyc[0][7:0], wr_addr[0][15:0], wr_data[0][7:0]}, 32'h01_0008_0B);
        check("flush_wr1", {wr_cyc[1][7:0], wr_addr[1][15:0], wr_data[1][7:0]}, 32'h02_0009_0A);
        check("flush_nrd", rd_cyc.size(), 0);
        check("flush_ndone", done_cyc.size(), 1);
        check("flush_done_cyc", done_cyc[0], 3);
        check("flush_line_kept", 32'(bus1.fill_line_o), 32'h76);
        check("flush_idle_bus", idle_nz, 0);

        run1(1'b1, 1'b1, 16'h0004, 16'h0004, 8'h5C, 0);
        check("both_wr0", {wr_cyc[0][7:0], wr_addr[0][15:0], wr_data[0][7:0]}, 32'h01_0004_0C);
        check("both_wr1", {wr_cyc[1][7:0], wr_addr[1][15:0], wr_data[1][7:0]}, 32'h02_0005_05);
        check("both_rd", {rd_cyc[0][7:0], rd_addr[0][7:0], rd_cyc[1][7:0], rd_addr[1][7:0]},
              32'h03_04_05_05);
        check("both_ndone", done_cyc.size(), 1);
        check("both_done_cyc", done_cyc[0], 7);
        check("both_line", 32'(bus1.fill_line_o), 32'h5C);

        run1(1'b0, 1'b1, 16'h0011, 16'h0000, 8'hFF, 2);
        check("poke_ndone", done_cyc.size(), 1);
        check("poke_done_cyc", done_cyc[0], 5);
        check("poke_nwr", wr_cyc.size(), 0);
        check("poke_nrd", rd_cyc.size(), 2);
        check("poke_line", 32'(bus1.fill_line_o), 32'h10);

        run1(1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h00, 0);
        check("top_rd0_addr", rd_addr[0], 32'hFFFE);
        check("top_rd1_addr", rd_addr[1], 32'hFFFF);
        check("top_line", 32'(bus1.fill_line_o), 32'hFE);

        @(negedge clk);
        bus3.fill_start_i   = 1'b1;
        bus3.fill_address_i = 16'h0002;
        @(posedge clk);
        #1;
        bus3.fill_start_i   = 1'b0;
        bus3.fill_address_i = 16'h1234;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus3.mem_read_o) begin
                rd3_cyc.push_back(c);
                rd3_addr.push_back(int'(bus3.mem_address_o));
            end
            if (bus3.done_o) done3_cyc.push_back(c);
        end
        check("lat3_nrd", rd3_cyc.size(), 2);
        check("lat3_rd", {rd3_cyc[0][7:0], rd3_addr[0][7:0], rd3_cyc[1][7:0], rd3_addr[1][7:0]},
              32'h01_02_05_03);
        check("lat3_ndone", done3_cyc.size(), 1);
        check("lat3_done_cyc", done3_cyc[0], 9);
        check("lat3_line", 32'(bus3.fill_line_o), 32'h32);

        @(negedge clk);
        bus1.fill_start_i   = 1'b1;
        bus1.fill_address_i = 16'h0006;
        @(posedge clk);
        #1;
        bus1.fill_start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(bus1.busy_o), 0);
        check("mrst_strobes", {30'd0, bus1.mem_read_o, bus1.mem_write_o}, 0);
        check("mrst_addr_data", {bus1.mem_address_o, 12'd0, bus1.mem_data_o}, 0);
        check("mrst_line", 32'(bus1.fill_line_o), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mrst_nodone", 32'(bus1.done_o), 0);
        end
        rst = 1'b0;
        run1(1'b0, 1'b1, 16'h0006, 16'h0000, 8'h00, 0);
        check("post_rst_ndone", done_cyc.size(), 1);
        check("post_rst_done_cyc", done_cyc[0], 5);
        check("post_rst_line", 32'(bus1.fill_line_o), 32'h76);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
